// File: rtl/fast_pkg.sv
// Shared definitions for the FAST2.0 ingress bitmap tagger: beat types,
// header field positions and the framing FSM states.
package fast_pkg;

  localparam logic [1:0] HDR  = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  localparam int unsigned BITMAP_LSB = 26;
  localparam int unsigned PORT_MSB   = 19;
  localparam int unsigned PORT_LSB   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } tagger_state_t;

endpackage

// File: rtl/fast_bitmap_tagger_tag_table.sv
// Per-ingress-port tag table: 16 x W registers, one synchronous write port,
// one combinational read port (a same-cycle read sees the old entry).
module tag_table #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [3:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [3:0]   rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem [16];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fast_bitmap_tagger.sv
// FAST2.0 ingress framing checker and module-bitmap tagger.
// Optional statistics counters are enabled by defining FAST_TAGGER_STATS_EN.
module fast_bitmap_tagger
  import fast_pkg::*;
#(
  parameter int unsigned N_MOD     = 8,
  parameter int unsigned w_pkt     = 134,
  parameter int unsigned MAX_BEATS = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pktin_data_wr,
  input  logic [w_pkt-1:0] pktin_data,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_addr,
  input  logic [N_MOD:0]   cfg_data,
  output logic             pktout_data_wr,
  output logic [w_pkt-1:0] pktout_data,
  output logic [31:0]      pkt_cnt,
  output logic [31:0]      drop_cnt,
  output logic [31:0]      trunc_cnt
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  tagger_state_t state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             out_wr_nxt;
  logic [w_pkt-1:0] out_data_nxt;
  logic [w_pkt-1:0] hdr_tagged;
  logic [w_pkt-1:0] synth_tail;
  logic [N_MOD:0]   entry;
  logic [1:0]       beat_type;
  logic             inc_pkt, inc_drop, inc_trunc;

  tag_table #(.W(N_MOD + 1)) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr      (cfg_wr),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (pktin_data[PORT_MSB:PORT_LSB]),
    .rd_data (entry)
  );

  assign beat_type = pktin_data[w_pkt-1 -: 2];

  always_comb begin
    synth_tail = '0;
    synth_tail[w_pkt-1 -: 2] = TAIL;
    hdr_tagged = pktin_data;
    hdr_tagged[BITMAP_LSB +: N_MOD] = entry[N_MOD] ? entry[N_MOD-1:0]
                                    : (pktin_data[BITMAP_LSB +: N_MOD] | entry[N_MOD-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      pktout_data_wr <= 1'b0;
      pktout_data    <= '0;
    end else begin
      state          <= state_nxt;
      beat_cnt       <= beat_cnt_nxt;
      pktout_data_wr <= out_wr_nxt;
      pktout_data    <= out_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    out_wr_nxt   = 1'b0;
    out_data_nxt = pktout_data;
    inc_pkt      = 1'b0;
    inc_drop     = 1'b0;
    inc_trunc    = 1'b0;
    if (pktin_data_wr) begin
      unique case (state)
        IDLE: begin
          if (beat_type == HDR) begin
            out_wr_nxt   = 1'b1;
            out_data_nxt = hdr_tagged;
            beat_cnt_nxt = CNT_W'(1);
            state_nxt    = IN_PKT;
          end else begin
            inc_drop = 1'b1;
          end
        end
        IN_PKT: begin
          // A stray header closes the open packet and is itself counted as dropped.
          if (beat_type == HDR) begin
            out_wr_nxt   = 1'b1;
            out_data_nxt = synth_tail;
            inc_trunc    = 1'b1;
            inc_drop     = 1'b1;
            state_nxt    = DROP;
          end else if (beat_type == TAIL) begin
            out_wr_nxt   = 1'b1;
            out_data_nxt = pktin_data;
            inc_pkt      = 1'b1;
            state_nxt    = IDLE;
          end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
            out_wr_nxt   = 1'b1;
            out_data_nxt = synth_tail;
            inc_trunc    = 1'b1;
            state_nxt    = DROP;
          end else begin
            out_wr_nxt   = 1'b1;
            out_data_nxt = pktin_data;
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
        DROP: begin
          if (beat_type == TAIL) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef FAST_TAGGER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (inc_pkt   && pkt_cnt   != '1) pkt_cnt   <= pkt_cnt + 32'd1;
      if (inc_drop  && drop_cnt  != '1) drop_cnt  <= drop_cnt + 32'd1;
      if (inc_trunc && trunc_cnt != '1) trunc_cnt <= trunc_cnt + 32'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = inc_pkt ^ inc_drop ^ inc_trunc;
  assign pkt_cnt   = '0;
  assign drop_cnt  = '0;
  assign trunc_cnt = '0;
`endif

endmodule

// File: doc/fast_bitmap_tagger.md
# fast_bitmap_tagger

Ingress stage placed directly upstream of the per-module NMID comparers in the FAST2.0 pipeline. Receives 134-bit FAST2.0 packet beats, checks packet framing, and writes the module bitmap in each header from a software-programmed per-ingress-port table. Every downstream comparer therefore sees a well-formed packet with its bitmap bit already decided. Malformed or overlong packets are terminated and dropped, so no downstream FSM waits forever for a tail.

## Interface
- `N_MOD`, default 8: number of function modules, i.e. bitmap width. Bitmap occupies header bits [26+N_MOD-1:26].
- `w_pkt`, default 134: FAST2.0 beat width.
- `MAX_BEATS`, default 128: maximum legal beats per packet, header and tail included.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `pktin_data_wr` in 1: input beat valid.
- `pktin_data` in w_pkt: input beat. [133:132] = 01 header, 11 body, 10 tail. Header [19:16] = ingress port.
- `cfg_wr` in 1: table write strobe.
- `cfg_addr` in 4: table entry, indexed by ingress port.
- `cfg_data` in N_MOD+1: bit N_MOD = mode (1 overwrite, 0 OR); [N_MOD-1:0] = bitmap.
- `pktout_data_wr` out 1: output beat valid.
- `pktout_data` out w_pkt: output beat.
- `pkt_cnt`, `drop_cnt`, `trunc_cnt` out 32 each: statistics (see Configuration).

## Operation
- FSM states:
  - IDLE: waiting for a header.
  - IN_PKT: forwarding a packet.
  - DROP: discarding until a tail.
- In IDLE:
  - Header beat: forward it with bitmap = table[port] (overwrite mode) or orig|table[port] (OR mode). Beat counter = 1. Go to IN_PKT.
  - Body or tail beat: discard, drop_cnt +1, stay in IDLE.
- In IN_PKT:
  - Body beat: forward unchanged, counter +1.
  - Tail beat: forward, pkt_cnt +1, go to IDLE.
- Header arriving in IN_PKT: emit a synthesized tail (type 10, bits [131:0] zero) in place of that header. trunc_cnt +1, drop_cnt +1. Go to DROP, which discards the new packet up to and including its tail.
- Overlong packet: a non-tail beat arriving while the counter equals MAX_BEATS-1 is replaced by a synthesized tail. trunc_cnt +1, go to DROP.
- In DROP:
  - Tail beat: discard, go to IDLE.
  - Header beat: discard and stay in DROP (no extra count).
- Table: 16 entries, reset value 0 with mode = 0, i.e. bitmap passes through unchanged. A `cfg_wr` in the same cycle as a header that reads the same entry: the header uses the old value. The new value applies from the next cycle on.
- All bits other than the bitmap field pass through unchanged.

## Timing
- Latency is exactly 1 cycle: a beat at edge t appears on `pktout_*` at edge t+1. No backpressure. Gaps in `pktin_data_wr` are preserved.
- `pktout_data_wr` is 0 in any cycle following an invalid or discarded input beat. `pktout_data` holds its last value in those cycles.
- Reset values:
  - `pktout_data_wr` = 0, `pktout_data` = 0.
  - Counters = 0, table = 0, FSM = IDLE.
- Reset asserted mid-packet: the remainder of that packet is discarded as orphan beats until the next header, and each discarded beat increments drop_cnt.
- Counters saturate at 32'hFFFF_FFFF.

## Configuration
- `FAST_TAGGER_STATS_EN` defined: the three 32-bit counters are implemented as specified.
- Not defined: the counter ports remain and are tied to 0. Framing, truncation and drop behaviour are unchanged.

## Structure
- Shared package `fast_pkg`:
  - beat type constants: HDR 2'b01, BODY 2'b11, TAIL 2'b10;
  - BITMAP_LSB = 26;
  - PORT_MSB/LSB = 19/16;
  - FSM state enumeration.
- One sub-module, `tag_table`: 16 x (N_MOD+1) register file with one write port and one combinational read port. Everything else lives in the top level.

## Test plan
- Table[3] = {1, 8'h80}; header with port 3 and bitmap 8'h01, two body beats, then tail → header output next cycle with bitmap 8'h80, body and tail unchanged; pkt_cnt = 1.
- Table[3] = {0, 8'h80}; same packet → bitmap 8'h81.
- Sequence header, body, header, body, tail → output is header, body, synthesized tail (type 10, zeros); second packet fully dropped; trunc_cnt = 1, drop_cnt = 1; FSM returns to IDLE.
- Two body beats and one tail in IDLE → no output; drop_cnt = 3.
- MAX_BEATS = 4: header plus 5 body beats plus tail → output is header, 2 body beats, synthesized tail; trunc_cnt = 1. The next well-formed packet is forwarded normally.
- `cfg_wr` to entry 5 in the same cycle as a port-5 header → old bitmap used. The next port-5 packet uses the new bitmap.
